div_sqrt_iter_ctrl: RTL and testbench
=====================================

Name: div_sqrt_iter_ctrl

Overview:
Iteration core of the div/sqrt unit, directly downstream of the operand decode/normalise stage. It takes the registered normalised mantissas, exponents and special-case flags from that stage. It runs a radix-2 restoring digit recurrence, one quotient/root bit per cycle. It delivers an unrounded quotient/root, a sticky bit and a biased result exponent to the normalise-and-round stage.

Parameters:
MANT_W, 52, fraction width; mantissa inputs are MANT_W+1 bits with the hidden bit at the MSB
EXP_W, 11, biased exponent width; BIAS = 2^(EXP_W-1)-1
N_ITER, MANT_W+3, recurrence steps: 1 integer bit + MANT_W fraction bits + guard bit + round bit

Ports:
Clk_CI  in  1  clock
Rst_RBI  in  1  reset, asynchronous, active-low
Div_start_SI  in  1  division start pulse; same cycle as raw operands upstream
Sqrt_start_SI  in  1  sqrt start pulse; same cycle as raw operands upstream
Kill_SI  in  1  abort current operation
Exp_a_DI, Exp_b_DI  in  EXP_W+1  normalised exponents, two's complement; valid the cycle after start
Mant_a_DI, Mant_b_DI  in  MANT_W+1  normalised mantissas with MSB=1 unless zero; valid the cycle after start
Inf_a_SI, Inf_b_SI, Zero_a_SI, Zero_b_SI, NaN_a_SI, NaN_b_SI  in  1 each  special flags; valid the cycle after start
Ready_SO  out  1  block can accept a start
Done_SO  out  1  one-cycle pulse: result outputs valid
Special_SO  out  1  result decided by flags; Quot_DO is don't-care
Div_op_SO  out  1  1 = division, 0 = sqrt; held with the result
Quot_DO  out  N_ITER  quotient/root; MSB = integer bit
Sticky_SO  out  1  OR of the final partial remainder
Exp_z_DO  out  EXP_W+2  signed biased result exponent, before normalisation

Behaviour:
- Reset values: state IDLE; Ready_SO=1; Done_SO, Special_SO, Div_op_SO, Quot_DO, Sticky_SO, Exp_z_DO all 0.
- States: IDLE, LOAD, ITER, DONE.
- IDLE:
  - Div_start_SI or Sqrt_start_SI with Kill_SI=0 -> LOAD; latch op type.
  - If both starts are high, division wins.
- LOAD (1 cycle):
  - Capture operands and flags.
  - If any flag is set -> DONE with Special_SO=1, no iterations.
  - Otherwise initialise the remainder, clear Quot, load the counter with N_ITER-1 -> ITER.
- ITER:
  - One bit per cycle, shifted into Quot from the LSB.
  - Counter decrements; at 0 -> DONE.
- DONE (1 cycle):
  - Done_SO=1; Sticky_SO = |remainder; outputs are registered.
  - Outputs hold until the next LOAD.
- Latency, start at cycle 0:
  - Normal: LOAD at cycle 1, ITER cycles 2..N_ITER+1, Done_SO at cycle N_ITER+2 (57 for defaults).
  - Special: Done_SO at cycle 2.
- Ready_SO is high in IDLE and DONE, so a start in the DONE cycle is accepted back-to-back. Starts in LOAD/ITER are ignored; the issuer must honour Ready_SO, and the bench asserts on violations.
- Kill_SI: in any state -> IDLE next cycle. No Done_SO; result outputs keep their previous values. Kill_SI with a start in the same cycle: kill wins and the start is dropped.
- Division:
  - Remainder width MANT_W+2; R0 = Mant_a, D = Mant_b.
  - Each step: if R>=D then q=1, R=(R-D)<<1; else q=0, R=R<<1.
  - Exp_z = Exp_a - Exp_b + BIAS, sign-extended to EXP_W+2 bits.
  - When Mant_a<Mant_b, Quot MSB=0 and downstream normalises.
- Sqrt:
  - e = Exp_a - BIAS. If e is odd, radicand = Mant_a<<1 and e = e-1; otherwise radicand = Mant_a.
  - Exp_z = (e>>>1) + BIAS.
  - Restoring root: each step brings down 2 radicand bits (zeros once exhausted). Trial = {Q,2'b01}; if R>=trial then q=1 and R=R-trial.
  - Remainder width MANT_W+5.
- Sign is not handled here; it comes from the upstream stage.

Optional Feature:
DIV_SQRT_EARLY_TERM_EN:
- Defined: in ITER, if the partial remainder becomes 0 after a step, the remaining quotient bits are zero-filled (Quot shifted left by the remaining count in one cycle) and the FSM goes to DONE next cycle. Sticky_SO=0 in that case.
- Undefined: always N_ITER iterations, fixed latency.
- Results are identical in both builds; only Done timing differs.

Test Plan:
1. Div 1.5/1.0 (Mant_a=1.1000..., Mant_b=1.0, exps 1023/1023) -> Done cycle 57, Quot_DO top bits 11 then zeros, Sticky 0, Exp_z 1023. With DIV_SQRT_EARLY_TERM_EN: Done cycle 4.
2. Div 1.0/1.5 -> Done cycle 57, Quot_DO = 0.101010...10 (55 bits), Sticky 1, Exp_z 1023.
3. Sqrt 4.0 (Exp_a 1025, mant 1.0) -> Quot_DO = 1.000...0, Exp_z 1024, Sticky 0. Sqrt 2.0 (Exp_a 1024) -> odd path, Quot_DO top bits 1.0110101000001..., Exp_z 1023, Sticky 1.
4. Div with Zero_b_SI=1 in LOAD -> Special_SO=1, Done cycle 2, Div_op_SO=1.
5. Kill_SI at cycle 10 of a division -> no Done_SO, Ready_SO=1 at cycle 11, previous results unchanged; a following start completes normally.
6. Start during ITER -> ignored, result of the first op unchanged. Start in the DONE cycle -> accepted, second Done exactly N_ITER+2 cycles later.

Source files
------------

// File: rtl/div_sqrt_iter_ctrl.sv
// Div/sqrt iteration core: radix-2 restoring recurrence, one quotient/root bit per cycle.
// Optional build macro DIV_SQRT_EARLY_TERM_EN ends the recurrence once the remainder reaches zero.
module div_sqrt_iter_ctrl #(
    parameter int MANT_W = 52,
    parameter int EXP_W  = 11,
    parameter int N_ITER = MANT_W + 3
) (
    input  logic              Clk_CI,
    input  logic              Rst_RBI,
    input  logic              Div_start_SI,
    input  logic              Sqrt_start_SI,
    input  logic              Kill_SI,
    input  logic [EXP_W:0]    Exp_a_DI,
    input  logic [EXP_W:0]    Exp_b_DI,
    input  logic [MANT_W:0]   Mant_a_DI,
    input  logic [MANT_W:0]   Mant_b_DI,
    input  logic              Inf_a_SI,
    input  logic              Inf_b_SI,
    input  logic              Zero_a_SI,
    input  logic              Zero_b_SI,
    input  logic              NaN_a_SI,
    input  logic              NaN_b_SI,
    output logic              Ready_SO,
    output logic              Done_SO,
    output logic              Special_SO,
    output logic              Div_op_SO,
    output logic [N_ITER-1:0] Quot_DO,
    output logic              Sticky_SO,
    output logic [EXP_W+1:0]  Exp_z_DO
);

    localparam int RD_W  = MANT_W + 2;
    localparam int RS_W  = N_ITER + 2;
    localparam int RAD_W = 2 * N_ITER;
    localparam int CNT_W = $clog2(N_ITER);
    localparam logic signed [EXP_W+1:0] BIAS     = (EXP_W+2)'(2 ** (EXP_W - 1) - 1);
    localparam logic [CNT_W-1:0]        CNT_INIT = CNT_W'(N_ITER - 1);

    typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_e;

    typedef struct packed {
        logic              special;
        logic              div_op;
        logic [N_ITER-1:0] quot;
        logic              sticky;
        logic [EXP_W+1:0]  exp_z;
    } result_t;

    state_e                  state_q, state_d;
    result_t                 res_q, res_d;
    logic                    op_div_q;
    logic [N_ITER-1:0]       rem_q;
    logic [MANT_W:0]         div_d_q;
    logic [RAD_W-1:0]        rad_q;
    logic [N_ITER-1:0]       qw_q;
    logic [CNT_W-1:0]        cnt_q;
    logic signed [EXP_W+1:0] exp_q;

    logic start, any_flag, last_step, early, q_bit;

    assign start    = Div_start_SI | Sqrt_start_SI;
    assign any_flag = Inf_a_SI | Inf_b_SI | Zero_a_SI | Zero_b_SI | NaN_a_SI | NaN_b_SI;

    // Operand decode for the LOAD cycle
    logic signed [EXP_W+1:0] exp_a_s, exp_b_s, div_exp, sqrt_e, sqrt_exp, load_exp;
    logic [RAD_W-1:0]        rad_init;

    assign exp_a_s  = {Exp_a_DI[EXP_W], Exp_a_DI};
    assign exp_b_s  = {Exp_b_DI[EXP_W], Exp_b_DI};
    assign div_exp  = exp_a_s - exp_b_s + BIAS;
    assign sqrt_e   = exp_a_s - BIAS;
    // floor(e/2) equals (e-1)/2 for odd e, so the shift covers both parities
    assign sqrt_exp = (sqrt_e >>> 1) + BIAS;
    assign load_exp = op_div_q ? div_exp : sqrt_exp;
    assign rad_init = {(sqrt_e[0] ? {Mant_a_DI, 1'b0} : {1'b0, Mant_a_DI}),
                       {(RAD_W - RD_W){1'b0}}};

    // Division step
    logic [RD_W-1:0] rd, div_rem_nxt;
    logic [MANT_W:0] rd_sub;
    logic            div_ge;

    assign rd          = rem_q[RD_W-1:0];
    assign div_ge      = rd >= {1'b0, div_d_q};
    assign rd_sub      = rd[MANT_W:0] - div_d_q;
    assign div_rem_nxt = div_ge ? {rd_sub, 1'b0} : {rd[MANT_W:0], 1'b0};

    // Sqrt step: stored remainder never exceeds N_ITER bits between steps
    logic [RS_W-1:0] rs, trial, sqrt_rem_nxt;
    logic            sqrt_ge;

    assign rs           = {rem_q, rad_q[RAD_W-1 -: 2]};
    assign trial        = {qw_q, 2'b01};
    assign sqrt_ge      = rs >= trial;
    assign sqrt_rem_nxt = sqrt_ge ? rs - trial : rs;

    logic [RS_W-1:0]   rem_nxt;
    logic [RAD_W-1:0]  rad_nxt;
    logic [N_ITER-1:0] qw_nxt, qw_fill;

    assign q_bit   = op_div_q ? div_ge : sqrt_ge;
    assign qw_nxt  = {qw_q[N_ITER-2:0], q_bit};
    assign rem_nxt = op_div_q ? RS_W'(div_rem_nxt) : sqrt_rem_nxt;
    assign rad_nxt = rad_q << 2;

`ifdef DIV_SQRT_EARLY_TERM_EN
    // sqrt also needs the unconsumed radicand to be zero, else later root bits could be set
    assign early   = (rem_nxt == '0) && (op_div_q || rad_nxt == '0);
    assign qw_fill = qw_nxt << cnt_q;
`else
    assign early   = 1'b0;
    assign qw_fill = qw_nxt;
`endif

    assign last_step = (cnt_q == '0) || early;

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LOAD;
            LOAD:    state_d = any_flag ? DONE : ITER;
            ITER:    if (last_step) state_d = DONE;
            DONE:    state_d = start ? LOAD : IDLE;
            default: state_d = IDLE;
        endcase
        if (Kill_SI) state_d = IDLE;
    end

    always_comb begin
        Ready_SO = 1'b0;
        Done_SO  = 1'b0;
        case (state_q)
            IDLE:    Ready_SO = 1'b1;
            DONE:    begin Ready_SO = 1'b1; Done_SO = 1'b1; end
            default: ;
        endcase
    end

    // Results only change on entry to DONE, so a kill leaves the previous result visible
    always_comb begin
        res_d = res_q;
        if (!Kill_SI) begin
            if (state_q == LOAD && any_flag) begin
                res_d.special = 1'b1;
                res_d.div_op  = op_div_q;
                res_d.quot    = '0;
                res_d.sticky  = 1'b0;
                res_d.exp_z   = load_exp;
            end else if (state_q == ITER && last_step) begin
                res_d.special = 1'b0;
                res_d.div_op  = op_div_q;
                res_d.quot    = qw_fill;
                res_d.sticky  = |rem_nxt;
                res_d.exp_z   = exp_q;
            end
        end
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            res_q    <= '0;
            op_div_q <= 1'b0;
            rem_q    <= '0;
            div_d_q  <= '0;
            rad_q    <= '0;
            qw_q     <= '0;
            cnt_q    <= '0;
            exp_q    <= '0;
        end else begin
            res_q <= res_d;
            if ((state_q == IDLE || state_q == DONE) && start && !Kill_SI)
                op_div_q <= Div_start_SI;
            case (state_q)
                LOAD: begin
                    rem_q   <= op_div_q ? N_ITER'(Mant_a_DI) : '0;
                    div_d_q <= Mant_b_DI;
                    rad_q   <= rad_init;
                    qw_q    <= '0;
                    cnt_q   <= CNT_INIT;
                    exp_q   <= load_exp;
                end
                ITER: begin
                    rem_q <= rem_nxt[N_ITER-1:0];
                    rad_q <= rad_nxt;
                    qw_q  <= early ? qw_fill : qw_nxt;
                    cnt_q <= cnt_q - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign Special_SO = res_q.special;
    assign Div_op_SO  = res_q.div_op;
    assign Quot_DO    = res_q.quot;
    assign Sticky_SO  = res_q.sticky;
    assign Exp_z_DO   = res_q.exp_z;

endmodule

// File: tb/tb_div_sqrt_iter_ctrl.sv
// Directed bench for div_sqrt_iter_ctrl: divide, sqrt, special, kill and back-to-back starts.
module tb_div_sqrt_iter_ctrl;

    localparam int MANT_W = 52;
    localparam int EXP_W  = 11;
    localparam int N_ITER = MANT_W + 3;

`ifdef DIV_SQRT_EARLY_TERM_EN
    localparam int T_1P5_DONE = 4;
    localparam int T_SQ4_DONE = 3;
`else
    localparam int T_1P5_DONE = N_ITER + 2;
    localparam int T_SQ4_DONE = N_ITER + 2;
`endif
    localparam int T_FULL = N_ITER + 2;

    localparam logic [MANT_W:0]   M_ONE = 53'h10000000000000;
    localparam logic [MANT_W:0]   M_1P5 = 53'h18000000000000;
    localparam logic [N_ITER-1:0] Q_1P5 = 55'h60000000000000;
    localparam logic [N_ITER-1:0] Q_2_3 = 55'h2AAAAAAAAAAAAA;
    localparam logic [N_ITER-1:0] Q_SQ4 = 55'h40000000000000;
    localparam logic [N_ITER-1:0] Q_SQ2 = 55'h5A827999FCEF32;

    logic              Clk_CI = 1'b0;
    logic              Rst_RBI = 1'b0;
    logic              Div_start_SI = 1'b0, Sqrt_start_SI = 1'b0, Kill_SI = 1'b0;
    logic [EXP_W:0]    Exp_a_DI = '0, Exp_b_DI = '0;
    logic [MANT_W:0]   Mant_a_DI = '0, Mant_b_DI = '0;
    logic              Inf_a_SI = 1'b0, Inf_b_SI = 1'b0, Zero_a_SI = 1'b0;
    logic              Zero_b_SI = 1'b0, NaN_a_SI = 1'b0, NaN_b_SI = 1'b0;
    logic              Ready_SO, Done_SO, Special_SO, Div_op_SO, Sticky_SO;
    logic [N_ITER-1:0] Quot_DO;
    logic [EXP_W+1:0]  Exp_z_DO;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int at;
    logic seen;

    div_sqrt_iter_ctrl #(.MANT_W(MANT_W), .EXP_W(EXP_W), .N_ITER(N_ITER)) dut (
        .Clk_CI(Clk_CI), .Rst_RBI(Rst_RBI),
        .Div_start_SI(Div_start_SI), .Sqrt_start_SI(Sqrt_start_SI), .Kill_SI(Kill_SI),
        .Exp_a_DI(Exp_a_DI), .Exp_b_DI(Exp_b_DI),
        .Mant_a_DI(Mant_a_DI), .Mant_b_DI(Mant_b_DI),
        .Inf_a_SI(Inf_a_SI), .Inf_b_SI(Inf_b_SI),
        .Zero_a_SI(Zero_a_SI), .Zero_b_SI(Zero_b_SI),
        .NaN_a_SI(NaN_a_SI), .NaN_b_SI(NaN_b_SI),
        .Ready_SO(Ready_SO), .Done_SO(Done_SO), .Special_SO(Special_SO),
        .Div_op_SO(Div_op_SO), .Quot_DO(Quot_DO), .Sticky_SO(Sticky_SO),
        .Exp_z_DO(Exp_z_DO)
    );

    always #5 Clk_CI = ~Clk_CI;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the negedge of the next cycle; sample then drive there
    task automatic step();
        @(negedge Clk_CI);
        cyc++;
    endtask

    task automatic start_op(input logic is_div, input logic is_sqrt);
        Div_start_SI  = is_div;
        Sqrt_start_SI = is_sqrt;
        cyc = 0;
    endtask

    task automatic load_ops(input logic [EXP_W:0] ea, input logic [EXP_W:0] eb,
                            input logic [MANT_W:0] ma, input logic [MANT_W:0] mb,
                            input logic [5:0] fl);
        step();
        Div_start_SI  = 1'b0;
        Sqrt_start_SI = 1'b0;
        Exp_a_DI  = ea;
        Exp_b_DI  = eb;
        Mant_a_DI = ma;
        Mant_b_DI = mb;
        {Inf_a_SI, Inf_b_SI, Zero_a_SI, Zero_b_SI, NaN_a_SI, NaN_b_SI} = fl;
    endtask

    task automatic wait_done(input int limit, output int done_at);
        done_at = -1;
        while (cyc < limit && done_at < 0) begin
            step();
            if (Done_SO) done_at = cyc;
        end
    endtask

    initial begin
        repeat (2) @(negedge Clk_CI);
        check("rst_ready",   Ready_SO,   1);
        check("rst_done",    Done_SO,    0);
        check("rst_special", Special_SO, 0);
        check("rst_divop",   Div_op_SO,  0);
        check("rst_quot",    Quot_DO,    0);
        check("rst_sticky",  Sticky_SO,  0);
        check("rst_expz",    Exp_z_DO,   0);
        Rst_RBI = 1'b1;
        step();
        check("idle_ready", Ready_SO, 1);

        // 1.5 / 1.0
        start_op(1'b1, 1'b0);
        load_ops(12'd1023, 12'd1023, M_1P5, M_ONE, 6'b0);
        wait_done(100, at);
        check("t1_done_cyc", at, T_1P5_DONE);
        check("t1_quot",     Quot_DO,    Q_1P5);
        check("t1_sticky",   Sticky_SO,  0);
        check("t1_expz",     Exp_z_DO,   1023);
        check("t1_special",  Special_SO, 0);
        check("t1_divop",    Div_op_SO,  1);
        step();
        check("t1_done_pulse", Done_SO, 0);
        check("t1_quot_hold",  Quot_DO, Q_1P5);

        // 1.0 / 1.5
        start_op(1'b1, 1'b0);
        load_ops(12'd1023, 12'd1023, M_ONE, M_1P5, 6'b0);
        wait_done(100, at);
        check("t2_done_cyc", at, T_FULL);
        check("t2_quot",     Quot_DO,   Q_2_3);
        check("t2_sticky",   Sticky_SO, 1);
        check("t2_expz",     Exp_z_DO,  1023);
        step();

        // sqrt 4.0 (even exponent)
        start_op(1'b0, 1'b1);
        load_ops(12'd1025, 12'd0, M_ONE, '0, 6'b0);
        wait_done(100, at);
        check("t3a_done_cyc", at, T_SQ4_DONE);
        check("t3a_quot",     Quot_DO,   Q_SQ4);
        check("t3a_sticky",   Sticky_SO, 0);
        check("t3a_expz",     Exp_z_DO,  1024);
        check("t3a_divop",    Div_op_SO, 0);
        step();

        // sqrt 2.0 (odd exponent)
        start_op(1'b0, 1'b1);
        load_ops(12'd1024, 12'd0, M_ONE, '0, 6'b0);
        wait_done(100, at);
        check("t3b_done_cyc", at, T_FULL);
        check("t3b_quot",     Quot_DO,   Q_SQ2);
        check("t3b_sticky",   Sticky_SO, 1);
        check("t3b_expz",     Exp_z_DO,  1023);
        step();

        // division by zero flag: special, no iterations
        start_op(1'b1, 1'b0);
        load_ops(12'd1023, 12'd1023, M_ONE, '0, 6'b000100);
        wait_done(20, at);
        check("t4_done_cyc", at, 2);
        check("t4_special",  Special_SO, 1);
        check("t4_divop",    Div_op_SO,  1);
        step();

        // start during ITER ignored, then start in DONE accepted
        start_op(1'b1, 1'b0);
        load_ops(12'd1023, 12'd1023, M_ONE, M_1P5, 6'b0);
        while (cyc < 20) step();
        check("t6_busy_ready", Ready_SO, 0);
        Sqrt_start_SI = 1'b1;
        step();
        Sqrt_start_SI = 1'b0;
        wait_done(100, at);
        check("t6_done_cyc", at, T_FULL);
        check("t6_quot",     Quot_DO,    Q_2_3);
        check("t6_divop",    Div_op_SO,  1);
        check("t6_special",  Special_SO, 0);
        check("t6_b2b_ready", Ready_SO,  1);
        start_op(1'b0, 1'b1);
        load_ops(12'd1024, 12'd0, M_ONE, '0, 6'b0);
        wait_done(100, at);
        check("t6_b2b_done_cyc", at, T_FULL);
        check("t6_b2b_quot",     Quot_DO,   Q_SQ2);
        check("t6_b2b_divop",    Div_op_SO, 0);
        step();

        // kill at cycle 10 of a division
        start_op(1'b1, 1'b0);
        load_ops(12'd1023, 12'd1023, M_ONE, M_1P5, 6'b0);
        seen = 1'b0;
        while (cyc < 10) begin
            step();
            if (Done_SO) seen = 1'b1;
        end
        Kill_SI = 1'b1;
        step();
        Kill_SI = 1'b0;
        check("t5_no_done",  seen,      0);
        check("t5_done",     Done_SO,   0);
        check("t5_ready",    Ready_SO,  1);
        check("t5_quot",     Quot_DO,   Q_SQ2);
        check("t5_divop",    Div_op_SO, 0);
        check("t5_sticky",   Sticky_SO, 1);
        start_op(1'b1, 1'b0);
        load_ops(12'd1023, 12'd1023, M_1P5, M_ONE, 6'b0);
        wait_done(100, at);
        check("t5_next_done_cyc", at, T_1P5_DONE);
        check("t5_next_quot",     Quot_DO,   Q_1P5);
        check("t5_next_divop",    Div_op_SO, 1);
        step();

        // kill and start in the same cycle: start dropped
        Kill_SI      = 1'b1;
        Div_start_SI = 1'b1;
        step();
        Kill_SI      = 1'b0;
        Div_start_SI = 1'b0;
        check("t7_ready", Ready_SO, 1);
        step();
        check("t7_ready2", Ready_SO, 1);
        check("t7_done",   Done_SO,  0);
        check("t7_quot",   Quot_DO,  Q_1P5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
